// File: rtl/udp_frame_tx.sv
// Snapshots Nregs 32-bit words on start and streams them out as one AXI-stream byte frame, word 0 first, MSB first.
// Optional macro UDP_FRAME_TX_SEQ_EN prefixes each frame with a 4-byte sequence number.
module udp_frame_tx #(
   parameter int Nregs = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [Nregs-1:0][31:0] rd_val,
   output logic                   tx_tvalid,
   input  logic                   tx_tready,
   output logic [7:0]             tx_tdata,
   output logic                   tx_tlast,
   output logic                   tx_tuser,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int NBYTES = Nregs * 4;
   localparam int CW     = $clog2(Nregs * 4 + 4);
   localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
`ifdef UDP_FRAME_TX_SEQ_EN
   localparam logic [1:0] S_HDR  = 2'd2;
`endif

   logic [1:0]           r_state;
   logic [CW-1:0]        r_cnt;
   logic [Nregs*32-1:0]  r_snap;
   logic                 r_done;
   logic                 w_hs;
   logic                 w_last;
   logic [31:0]          w_shift;
   logic [7:0]           w_byte;
   logic [7:0]           w_tdata;

`ifdef UDP_FRAME_TX_SEQ_EN
   logic [31:0]          r_seq;
   logic [31:0]          r_seq_cap;
   logic [7:0]           w_hdr_byte;

   assign w_hdr_byte = 8'(r_seq_cap >> (32'(2'd3 - r_cnt[1:0]) << 3));
`endif

   assign w_hs   = tx_tvalid & tx_tready;
   assign w_last = (r_state == S_SEND) && (r_cnt == LAST_CNT);

   // word index selects a 32-bit lane; byte lane 0 is the most significant byte
   assign w_shift = (32'(r_cnt >> 2) << 5) + (32'(2'd3 - r_cnt[1:0]) << 3);
   assign w_byte  = 8'(r_snap >> w_shift);

   always_comb begin
      w_tdata = 8'h00;
      case (r_state)
         S_SEND:  w_tdata = w_byte;
`ifdef UDP_FRAME_TX_SEQ_EN
         S_HDR:   w_tdata = w_hdr_byte;
`endif
         default: w_tdata = 8'h00;
      endcase
   end

   assign tx_tvalid  = (r_state != S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign tx_tdata   = w_tdata;
   assign tx_tlast   = w_last;
   assign tx_tuser   = 1'b0;
   assign frame_done = r_done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_snap    <= '0;
         r_done    <= 1'b0;
`ifdef UDP_FRAME_TX_SEQ_EN
         r_seq     <= '0;
         r_seq_cap <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_snap <= rd_val;
                  r_cnt  <= '0;
`ifdef UDP_FRAME_TX_SEQ_EN
                  r_seq_cap <= r_seq;
                  r_state   <= S_HDR;
`else
                  r_state   <= S_SEND;
`endif
               end
            end
`ifdef UDP_FRAME_TX_SEQ_EN
            S_HDR: begin
               if (w_hs) begin
                  if (r_cnt == CW'(3)) begin
                     r_cnt   <= '0;
                     r_state <= S_SEND;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
`endif
            S_SEND: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
`ifdef UDP_FRAME_TX_SEQ_EN
                     r_seq   <= r_seq + 32'd1;
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_frame_tx.sv
// Randomized scoreboard bench for udp_frame_tx; the reference model builds whole frames from the captured words.
module tb_udp_frame_tx;

   localparam int NR = 16;

   logic                clk = 1'b0;
   logic                resetn;
   logic                start;
   logic [NR-1:0][31:0] rd_val;
   logic                tx_tvalid;
   logic                tx_tready;
   logic [7:0]          tx_tdata;
   logic                tx_tlast;
   logic                tx_tuser;
   logic                busy;
   logic                frame_done;

   always #5 clk = ~clk;

   udp_frame_tx #(.Nregs(NR)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .rd_val     (rd_val),
      .tx_tvalid  (tx_tvalid),
      .tx_tready  (tx_tready),
      .tx_tdata   (tx_tdata),
      .tx_tlast   (tx_tlast),
      .tx_tuser   (tx_tuser),
      .busy       (busy),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [7:0] d;
      logic       l;
   } exp_t;

   exp_t        q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        exp_done = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_d = 8'h00;
   logic        prev_l = 1'b0;
   logic [31:0] m_seq = 32'd0;
   int          tr_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole frame as the receiver would expect it: optional sequence header, then words MSB first.
   function automatic void push_frame(input logic [NR-1:0][31:0] v);
      exp_t e;
`ifdef UDP_FRAME_TX_SEQ_EN
      for (int i = 0; i < 4; i++) begin
         e.d = 8'(m_seq >> (8 * (3 - i)));
         e.l = 1'b0;
         q.push_back(e);
      end
`endif
      for (int w = 0; w < NR; w++) begin
         for (int b = 0; b < 4; b++) begin
            e.d = 8'(v[w] >> (8 * (3 - b)));
            e.l = (w == NR - 1) && (b == 3);
            q.push_back(e);
         end
      end
   endfunction

   // Model + monitor: everything sampled mid-cycle, describing the coming rising edge.
   always @(negedge clk) begin
      logic was_empty;
      exp_t e;
      if (!resetn) begin
         check("rst_tvalid", 32'(tx_tvalid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_frame_done", 32'(frame_done), 32'd0);
         check("rst_tdata", 32'(tx_tdata), 32'd0);
         check("rst_tlast", 32'(tx_tlast), 32'd0);
         check("rst_tuser", 32'(tx_tuser), 32'd0);
         q.delete();
         exp_done   = 1'b0;
         prev_stall = 1'b0;
         m_seq      = 32'd0;
      end else begin
         was_empty = (q.size() == 0);
         check("busy", 32'(busy), 32'(!was_empty));
         check("tvalid", 32'(tx_tvalid), 32'(!was_empty));
         check("frame_done", 32'(frame_done), 32'(exp_done));
         check("tuser", 32'(tx_tuser), 32'd0);
         if (!tx_tvalid) check("idle_tlast", 32'(tx_tlast), 32'd0);
         if (prev_stall) begin
            check("stall_tvalid", 32'(tx_tvalid), 32'd1);
            check("stall_tdata", 32'(tx_tdata), 32'(prev_d));
            check("stall_tlast", 32'(tx_tlast), 32'(prev_l));
         end
         exp_done = 1'b0;
         if (tx_tvalid && tx_tready) begin
            if (was_empty) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: got %0h expected no transfer at %0t", tx_tdata, $time);
            end else begin
               e = q.pop_front();
               check("tdata", 32'(tx_tdata), 32'(e.d));
               check("tlast", 32'(tx_tlast), 32'(e.l));
               if (e.l) begin
                  exp_done = 1'b1;
                  m_seq    = m_seq + 32'd1;
               end
            end
         end
         prev_stall = tx_tvalid && !tx_tready;
         prev_d     = tx_tdata;
         prev_l     = tx_tlast;
         if (start && was_empty) push_frame(rd_val);
      end
   end

   initial begin
      int p;
      p = 0;
      tx_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         p++;
         case (tr_mode)
            1:       tx_tready = (p % 4 == 0) || (p % 4 == 3);
            2:       tx_tready = ($urandom_range(0, 2) != 0);
            default: tx_tready = 1'b1;
         endcase
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      if (busy || q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_timeout: got busy=%0d pending=%0d expected idle", busy, q.size());
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic rand_words();
      for (int k = 0; k < NR; k++) rd_val[k] = $urandom();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      for (int k = 0; k < NR; k++) rd_val[k] = 32'h01020304 + 32'(k) * 32'h04040404;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      // basic frame: bytes 0x01..0x40
      pulse_start();
      wait_idle(200);

      // backpressure 1,0,0,1
      tr_mode = 1;
      pulse_start();
      wait_idle(400);
      tr_mode = 0;

      // snapshot protection and start ignored mid-frame
      pulse_start();
      repeat (9) @(posedge clk);
      #1;
      rand_words();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle(200);

      // back-to-back with start held high
      @(posedge clk);
      #1 start = 1'b1;
      repeat (3 * 65 + 5) begin
         @(posedge clk);
         #1 rand_words();
      end
      start = 1'b0;
      wait_idle(200);

      // reset mid-frame, then a fresh frame
      pulse_start();
      repeat (19) @(posedge clk);
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      rand_words();
      pulse_start();
      wait_idle(200);

      // random traffic with random backpressure and stray starts
      tr_mode = 2;
      for (int f = 0; f < 6; f++) begin
         rand_words();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         pulse_start();
         repeat ($urandom_range(5, 60)) @(posedge clk);
         #1 rand_words();
         start = ($urandom_range(0, 1) == 1);
         @(posedge clk);
         #1 start = 1'b0;
         wait_idle(600);
      end
      tr_mode = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/udp_frame_tx.md
Name: udp_frame_tx

Overview:
Register read-back serializer. It is the transmit counterpart of the UDP register-write receiver.
- On a start pulse it snapshots Nregs 32-bit words.
- It emits them as one AXI-stream byte frame toward the MAC/UDP TX FIFO.
- The frame layout mirrors the receiver: Nregs*4 payload bytes, tlast on the final byte.

Parameters:
Nregs, 16, number of 32-bit words per frame; legal range 1..64.

Ports:
clk  input  1  system clock; all logic is on this single clock.
resetn  input  1  asynchronous active-low reset.
start  input  1  request one frame; sampled only while busy=0.
rd_val  input  Nregs x 32 (packed [Nregs-1:0][31:0])  register values to send.
tx_tvalid  output  1  AXI-stream valid.
tx_tready  input  1  AXI-stream ready from the TX FIFO.
tx_tdata  output  8  frame byte.
tx_tlast  output  1  high on the final byte of the frame.
tx_tuser  output  1  error flag; driven 0 always.
busy  output  1  high while a frame is in progress.
frame_done  output  1  one-cycle pulse when the last byte is accepted.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Outputs: tx_tvalid=0, tx_tdata=0, tx_tlast=0, tx_tuser=0, busy=0, frame_done=0.
  - FSM goes to IDLE. Byte counter=0. Snapshot buffer=0.
- States: IDLE, SEND, plus HDR when the optional feature is enabled.
- IDLE, start=1 at rising edge N:
  - Capture rd_val into the snapshot buffer in the same edge.
  - Set busy=1 and enter SEND.
  - tx_tvalid=1 from cycle N+1, with the first byte on tx_tdata.
  - Later changes on rd_val do not affect the frame in flight.
- Byte order: word 0 first; within each word MSB first (bits 31:24, 23:16, 15:8, 7:0). This is network order.
- Byte counter: 0..Nregs*4-1. It advances only on a handshake (tx_tvalid & tx_tready).
- Holding under backpressure: tx_tdata and tx_tlast hold stable while tx_tvalid=1 and tx_tready=0. tx_tvalid is never withdrawn mid-frame.
- No bubbles: with tx_tready held at 1, one byte is transferred per clock. A full frame takes Nregs*4 consecutive cycles.
- tx_tlast=1 only while the counter equals Nregs*4-1.
- Last handshake:
  - Return to IDLE.
  - Next cycle: tx_tvalid=0, tx_tlast=0, busy=0.
  - frame_done pulses for exactly that one cycle.
- start while busy=1 is ignored, including on the last-handshake cycle. It is not queued.
- Earliest back-to-back: start asserted the cycle busy falls. The gap between frames is then one idle cycle.
- tx_tready=1 while tx_tvalid=0 has no effect.
- Reset mid-frame: the frame is truncated with no tlast. The downstream FIFO/MAC must tolerate this. No recovery state is kept.
- Counter width: $clog2(Nregs*4+4) bits.

Optional Feature:
Macro: UDP_FRAME_TX_SEQ_EN.
- Defined:
  - A 32-bit sequence counter resets to 0.
  - Each frame is prefixed by a HDR state that emits the counter as 4 bytes, MSB first, before the payload.
  - Frame length is Nregs*4+4 bytes; tlast stays on the final payload byte.
  - The counter is captured at start and increments by 1 at frame_done, wrapping 0xFFFFFFFF->0.
  - Reset mid-frame returns it to 0.
- Not defined: no HDR state, no counter logic, frame is exactly Nregs*4 bytes.

Test Plan:
1. Basic frame (Nregs=16, rd_val[k]=32'h01020304+k*32'h04040404, tready=1, one start) -> 64 bytes 0x01..0x40 in order on consecutive cycles. tlast only on 0x40. frame_done pulses one cycle after that byte; busy=0 that same cycle.
2. Backpressure (tready toggles 1,0,0,1 pattern) -> byte sequence identical to test 1. tdata/tlast stable during every stall. tvalid never drops before tlast handshake.
3. Snapshot and ignore (change rd_val and pulse start at byte 10) -> frame bytes still match the original values. No second frame. Exactly one frame_done.
4. Back-to-back (start held high continuously) -> frames separated by exactly one idle cycle. Each frame carries 64 bytes.
5. Reset mid-frame (resetn low at byte 20 for 3 cycles, then start) -> tvalid=0 during reset, asynchronously. The next frame starts again from byte 0x01.
6. With UDP_FRAME_TX_SEQ_EN (3 frames) -> headers 00 00 00 00 / 00 00 00 01 / 00 00 00 02 precede the payloads. Each frame is 68 bytes.
